// File: rtl/exp_ctrl_fsm.sv
// Exposure control FSM: ISO/SS/F selection, lux and flash-LUT handshakes with timeout, result display.
// Optional periodic re-metering from DISP is built in when AUTO_REMETER_EN is defined.
module exp_ctrl_fsm #(
  parameter int unsigned SET_W          = 4,
  parameter int unsigned LUX_W          = 8,
  parameter int unsigned ADDR_W         = 24,  // must be >= 3*SET_W + LUX_W
  parameter int unsigned TIMEOUT        = 255, // must be >= 1
  parameter int unsigned REMETER_PERIOD = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pb_press,
  input  logic [SET_W-1:0]  enc_count,
  input  logic [LUX_W-1:0]  lux_val,
  input  logic              lux_ready,
  output logic              lux_valid,
  input  logic [7:0]        fd,
  input  logic              fd_ready,
  output logic [ADDR_W-1:0] fd_address,
  output logic              fd_valid,
  output logic [3:0]        display_out,
  output logic [1:0]        display_sel,
  output logic              err
);

  typedef enum logic [2:0] {
    StIdle, StIsoSel, StSsSel, StFSel, StMeter, StLut, StDisp, StErr
  } state_e;

  localparam logic [1:0] PbShort  = 2'b01;
  localparam logic [1:0] PbLong   = 2'b10;
  localparam logic [1:0] PbXLong  = 2'b11;
  localparam int unsigned ToW     = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   iso_q, iso_d, ss_q, ss_d, f_q, f_d;
  logic [LUX_W-1:0]   lux_q, lux_d;
  logic [2:0]         res_q, res_d;
  logic               f_set_q, f_set_d;
  logic               prev_f_q, prev_f_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic               lux_valid_q, lux_valid_d;
  logic               fd_valid_q, fd_valid_d;
  logic [ADDR_W-1:0]  fd_address_q, fd_address_d;
  logic [3:0]         display_out_q, display_out_d;
  logic [1:0]         display_sel_q, display_sel_d;
  logic               err_q, err_d;
  logic [3:0]         enc_disp;
  logic               unused_fd;

`ifdef AUTO_REMETER_EN
  localparam int unsigned RmW = $clog2(REMETER_PERIOD + 1);
  logic [RmW-1:0] rm_cnt_q, rm_cnt_d;
`endif

  assign unused_fd = ^fd[7:3];

  if (SET_W >= 4) begin : g_enc_trunc
    assign enc_disp = enc_count[3:0];
  end else begin : g_enc_zext
    assign enc_disp = 4'(enc_count);
  end

  always_comb begin
    state_d     = state_q;
    iso_d       = iso_q;
    ss_d        = ss_q;
    f_d         = f_q;
    lux_d       = lux_q;
    res_d       = res_q;
    f_set_d     = f_set_q;
    prev_f_d    = prev_f_q;
    to_cnt_d    = to_cnt_q;
    lux_valid_d = lux_valid_q;
    fd_valid_d  = fd_valid_q;
`ifdef AUTO_REMETER_EN
    rm_cnt_d    = '0;
`endif

    case (state_q)
      StIdle: begin
        iso_d       = '0;
        ss_d        = '0;
        f_d         = '0;
        lux_d       = '0;
        res_d       = '0;
        f_set_d     = 1'b0;
        prev_f_d    = 1'b0;
        lux_valid_d = 1'b0;
        fd_valid_d  = 1'b0;
        state_d     = StIsoSel;
      end
      StIsoSel: begin
        iso_d = enc_count;
        if (pb_press == PbShort) state_d = StSsSel;
      end
      StSsSel: begin
        ss_d     = enc_count;
        prev_f_d = 1'b0;
        if (pb_press == PbShort) state_d = StFSel;
        else if (pb_press == PbLong && f_set_q) state_d = StMeter;
        else if (pb_press == PbXLong) state_d = StIsoSel;
      end
      StFSel: begin
        f_d      = enc_count;
        f_set_d  = 1'b1;
        prev_f_d = 1'b1;
        if (pb_press == PbShort) state_d = StSsSel;
        else if (pb_press == PbLong) state_d = StMeter;
        else if (pb_press == PbXLong) state_d = StIsoSel;
      end
      StMeter: begin
        // First cycle in the state raises valid; ready only counts once valid is visible.
        if (!lux_valid_q) begin
          lux_valid_d = 1'b1;
          to_cnt_d    = '0;
        end else if (lux_ready) begin
          lux_d       = lux_val;
          lux_valid_d = 1'b0;
          state_d     = StLut;
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          lux_valid_d = 1'b0;
          state_d     = StErr;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StLut: begin
        if (!fd_valid_q) begin
          fd_valid_d = 1'b1;
          to_cnt_d   = '0;
        end else if (fd_ready) begin
          res_d      = fd[2:0];
          fd_valid_d = 1'b0;
          state_d    = StDisp;
        end else if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
          fd_valid_d = 1'b0;
          state_d    = StErr;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StDisp: begin
        if (pb_press == PbShort) state_d = StMeter;
        else if (pb_press == PbLong) state_d = prev_f_q ? StFSel : StSsSel;
        else if (pb_press == PbXLong) state_d = StIsoSel;
`ifdef AUTO_REMETER_EN
        else if (rm_cnt_q == RmW'(REMETER_PERIOD - 1)) state_d = StMeter;
        else rm_cnt_d = rm_cnt_q + RmW'(1);
`endif
      end
      StErr: begin
        if (pb_press != 2'b00) state_d = StIsoSel;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the state being entered.
    display_sel_d = 2'b11;
    display_out_d = 4'h8;
    err_d         = 1'b0;
    fd_address_d  = fd_address_q;
    case (state_d)
      StIsoSel: begin
        display_sel_d = 2'b00;
        display_out_d = enc_disp;
      end
      StSsSel: begin
        display_sel_d = 2'b01;
        display_out_d = enc_disp;
      end
      StFSel: begin
        display_sel_d = 2'b10;
        display_out_d = enc_disp;
      end
      StMeter, StLut: display_out_d = 4'h2;
      StDisp:         display_out_d = {1'b0, res_d};
      StErr: begin
        display_out_d = 4'hE;
        err_d         = 1'b1;
      end
      default: begin
        display_sel_d = 2'b00;
        fd_address_d  = '0;
      end
    endcase
    if (state_d == StLut && state_q != StLut) begin
      fd_address_d = ADDR_W'({iso_q, ss_q, f_q, lux_d});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      iso_q         <= '0;
      ss_q          <= '0;
      f_q           <= '0;
      lux_q         <= '0;
      res_q         <= '0;
      f_set_q       <= 1'b0;
      prev_f_q      <= 1'b0;
      to_cnt_q      <= '0;
      lux_valid_q   <= 1'b0;
      fd_valid_q    <= 1'b0;
      fd_address_q  <= '0;
      display_out_q <= 4'h8;
      display_sel_q <= 2'b00;
      err_q         <= 1'b0;
`ifdef AUTO_REMETER_EN
      rm_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      iso_q         <= iso_d;
      ss_q          <= ss_d;
      f_q           <= f_d;
      lux_q         <= lux_d;
      res_q         <= res_d;
      f_set_q       <= f_set_d;
      prev_f_q      <= prev_f_d;
      to_cnt_q      <= to_cnt_d;
      lux_valid_q   <= lux_valid_d;
      fd_valid_q    <= fd_valid_d;
      fd_address_q  <= fd_address_d;
      display_out_q <= display_out_d;
      display_sel_q <= display_sel_d;
      err_q         <= err_d;
`ifdef AUTO_REMETER_EN
      rm_cnt_q      <= rm_cnt_d;
`endif
    end
  end

  assign lux_valid   = lux_valid_q;
  assign fd_valid    = fd_valid_q;
  assign fd_address  = fd_address_q;
  assign display_out = display_out_q;
  assign display_sel = display_sel_q;
  assign err         = err_q;

endmodule

// File: tb/tb_exp_ctrl_fsm.sv
// Self-checking bench for exp_ctrl_fsm: selection flow, handshakes, timeout/ERR, display navigation.
// The re-meter scenario only runs when AUTO_REMETER_EN is defined.
module tb_exp_ctrl_fsm;
  localparam int unsigned SetW    = 4;
  localparam int unsigned LuxW    = 8;
  localparam int unsigned AddrW   = 24;
  localparam int unsigned Timeout = 4;
  localparam int unsigned Period  = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       pb_press;
  logic [SetW-1:0]  enc_count;
  logic [LuxW-1:0]  lux_val;
  logic             lux_ready;
  logic             lux_valid;
  logic [7:0]       fd;
  logic             fd_ready;
  logic [AddrW-1:0] fd_address;
  logic             fd_valid;
  logic [3:0]       display_out;
  logic [1:0]       display_sel;
  logic             err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AddrW-1:0] addr_sb[$];
  logic [3:0]       disp_sb[$];

  exp_ctrl_fsm #(
    .SET_W(SetW), .LUX_W(LuxW), .ADDR_W(AddrW), .TIMEOUT(Timeout), .REMETER_PERIOD(Period)
  ) dut (
    .clk(clk), .rst(rst), .pb_press(pb_press), .enc_count(enc_count), .lux_val(lux_val),
    .lux_ready(lux_ready), .lux_valid(lux_valid), .fd(fd), .fd_ready(fd_ready),
    .fd_address(fd_address), .fd_valid(fd_valid), .display_out(display_out),
    .display_sel(display_sel), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] code);
    pb_press = code;
    step();
    pb_press = 2'b00;
  endtask

  // Drives a full lux + LUT handshake from just-entered METER; results go through the scoreboard.
  task automatic test_handshake(input logic [7:0] lux, input logic [7:0] fdv,
                                input logic [3:0] e_iso, input logic [3:0] e_ss,
                                input logic [3:0] e_f);
    bit seen;
    logic [AddrW-1:0] exp_addr;
    logic [3:0] exp_disp;
    lux_val   = lux;
    lux_ready = 1'b1;
    addr_sb.push_back({4'h0, e_iso, e_ss, e_f, lux});
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = lux_valid; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL hs_lux_valid: got %b want 1", lux_valid); end
    step();
    lux_ready = 1'b0;
    n_cmp++;
    if (lux_valid !== 1'b0) begin n_bad++; $display("FAIL hs_lux_drop: got %b want 0", lux_valid); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = fd_valid; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL hs_fd_valid: got %b want 1", fd_valid); end
    exp_addr = addr_sb.pop_front();
    n_cmp++;
    if (fd_address !== exp_addr) begin
      n_bad++; $display("FAIL hs_fd_address: got %h want %h", fd_address, exp_addr);
    end
    fd       = fdv;
    fd_ready = 1'b1;
    disp_sb.push_back({1'b0, fdv[2:0]});
    step();
    fd_ready = 1'b0;
    exp_disp = disp_sb.pop_front();
    n_cmp++;
    if (fd_valid !== 1'b0 || display_sel !== 2'b11 || display_out !== exp_disp) begin
      n_bad++;
      $display("FAIL hs_disp: got valid=%b sel=%b out=%h want valid=0 sel=11 out=%h",
               fd_valid, display_sel, display_out, exp_disp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (lux_valid !== 1'b0 || fd_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: got lv=%b fv=%b err=%b want 0 0 0",
                        lux_valid, fd_valid, err);
    end
    n_cmp++;
    if (fd_address !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", fd_address); end
    n_cmp++;
    if (display_out !== 4'b1000 || display_sel !== 2'b00) begin
      n_bad++; $display("FAIL reset_disp: got out=%h sel=%b want 8 00", display_out, display_sel);
    end
    enc_count = 4'd3;
    rst = 1'b0;
    step();
    n_cmp++;
    if (display_sel !== 2'b00 || display_out !== 4'h3) begin
      n_bad++; $display("FAIL reset_to_iso: got sel=%b out=%h want 00 3", display_sel, display_out);
    end
  endtask

  task automatic test_select();
    enc_count = 4'd3;
    press(2'b01);
    n_cmp++;
    if (display_sel !== 2'b01) begin n_bad++; $display("FAIL sel_ss: got %b want 01", display_sel); end
    enc_count = 4'd5;
    press(2'b01);
    n_cmp++;
    if (display_sel !== 2'b10) begin n_bad++; $display("FAIL sel_f: got %b want 10", display_sel); end
    enc_count = 4'd7;
    press(2'b10);
    n_cmp++;
    if (display_sel !== 2'b11 || display_out !== 4'h2 || lux_valid !== 1'b0) begin
      n_bad++; $display("FAIL sel_meter: got sel=%b out=%h lv=%b want 11 2 0",
                        display_sel, display_out, lux_valid);
    end
    test_handshake(8'h40, 8'h06, 4'd3, 4'd5, 4'd7);
  endtask

  task automatic test_ss_long();
    press(2'b11);
    n_cmp++;
    if (display_sel !== 2'b00) begin n_bad++; $display("FAIL disp_xlong: got %b want 00", display_sel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    enc_count = 4'd9;
    step();
    press(2'b01);
    press(2'b10);
    n_cmp++;
    if (display_sel !== 2'b01) begin
      n_bad++; $display("FAIL ss_long_no_f: got sel=%b want 01", display_sel);
    end
    press(2'b01);
    press(2'b01);
    press(2'b10);
    n_cmp++;
    if (display_sel !== 2'b11 || display_out !== 4'h2) begin
      n_bad++; $display("FAIL ss_long_f_set: got sel=%b out=%h want 11 2", display_sel, display_out);
    end
    test_handshake(8'h11, 8'h05, 4'd9, 4'd9, 4'd9);
    press(2'b10);
    n_cmp++;
    if (display_sel !== 2'b01) begin n_bad++; $display("FAIL disp_long_ss: got %b want 01", display_sel); end
  endtask

  task automatic test_disp_nav();
    press(2'b01);
    press(2'b10);
    test_handshake(8'h22, 8'h03, 4'd9, 4'd9, 4'd9);
    press(2'b10);
    n_cmp++;
    if (display_sel !== 2'b10) begin n_bad++; $display("FAIL disp_long_f: got %b want 10", display_sel); end
    press(2'b10);
    test_handshake(8'hA5, 8'hF9, 4'd9, 4'd9, 4'd9);
    press(2'b11);
    n_cmp++;
    if (display_sel !== 2'b00) begin n_bad++; $display("FAIL disp_xlong_iso: got %b want 00", display_sel); end
  endtask

  task automatic test_timeout();
    bit seen;
    int waited;
    lux_ready = 1'b0;
    press(2'b01);
    press(2'b10);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = lux_valid; end
    end
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (!err) begin step(); waited++; end
    end
    n_cmp++;
    if (!seen || waited != Timeout) begin
      n_bad++; $display("FAIL to_cycles: got valid_seen=%b waited=%0d want 1 %0d", seen, waited, Timeout);
    end
    n_cmp++;
    if (err !== 1'b1 || lux_valid !== 1'b0 || display_out !== 4'hE || display_sel !== 2'b11) begin
      n_bad++; $display("FAIL to_err: got err=%b lv=%b out=%h sel=%b want 1 0 e 11",
                        err, lux_valid, display_out, display_sel);
    end
    step();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", err); end
    press(2'b01);
    n_cmp++;
    if (err !== 1'b0 || display_sel !== 2'b00 || display_out !== 4'h9) begin
      n_bad++; $display("FAIL to_clear: got err=%b sel=%b out=%h want 0 00 9",
                        err, display_sel, display_out);
    end
  endtask

  task automatic test_timeout_race();
    bit seen;
    logic [AddrW-1:0] exp_addr;
    logic [3:0] exp_disp;
    press(2'b01);
    press(2'b10);
    lux_val   = 8'h33;
    lux_ready = 1'b1;
    addr_sb.push_back({4'h0, 4'd9, 4'd9, 4'd9, 8'h33});
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = lux_valid; end
    end
    step();
    lux_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = fd_valid; end
    end
    exp_addr = addr_sb.pop_front();
    n_cmp++;
    if (!seen || fd_address !== exp_addr) begin
      n_bad++; $display("FAIL race_addr: got fv=%b addr=%h want 1 %h", seen, fd_address, exp_addr);
    end
    for (int i = 0; i < Timeout - 1; i++) step();
    n_cmp++;
    if (fd_valid !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL race_waiting: got fv=%b err=%b want 1 0", fd_valid, err);
    end
    fd       = 8'h07;
    fd_ready = 1'b1;
    disp_sb.push_back(4'h7);
    step();
    fd_ready = 1'b0;
    exp_disp = disp_sb.pop_front();
    n_cmp++;
    if (err !== 1'b0 || display_sel !== 2'b11 || display_out !== exp_disp || fd_valid !== 1'b0) begin
      n_bad++; $display("FAIL race_ready_wins: got err=%b sel=%b out=%h fv=%b want 0 11 %h 0",
                        err, display_sel, display_out, fd_valid, exp_disp);
    end
  endtask

`ifdef AUTO_REMETER_EN
  task automatic test_auto_remeter();
    int k;
    bit hit;
    hit = 1'b0;
    k   = 0;
    for (int i = 0; i < 20; i++) begin
      if (!hit) begin
        step();
        k++;
        hit = (display_out === 4'h2 && display_sel === 2'b11);
      end
    end
    n_cmp++;
    if (!hit || k != Period) begin
      n_bad++; $display("FAIL auto_period: got hit=%b cycles=%0d want 1 %0d", hit, k, Period);
    end
    test_handshake(8'h44, 8'h02, 4'd9, 4'd9, 4'd9);
    for (int i = 0; i < Period - 2; i++) step();
    press(2'b01);
    n_cmp++;
    if (display_out !== 4'h2 || display_sel !== 2'b11) begin
      n_bad++; $display("FAIL auto_press: got out=%h sel=%b want 2 11", display_out, display_sel);
    end
    test_handshake(8'h45, 8'h01, 4'd9, 4'd9, 4'd9);
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    press(2'b01);
    lux_val   = 8'h77;
    lux_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin step(); seen = lux_valid; end
    end
    lux_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    lux_ready = 1'b0;
    n_cmp++;
    if (!seen || lux_valid !== 1'b0 || display_out !== 4'h8 || fd_address !== '0) begin
      n_bad++; $display("FAIL reset_mid: got seen=%b lv=%b out=%h addr=%h want 1 0 8 0",
                        seen, lux_valid, display_out, fd_address);
    end
    step();
    n_cmp++;
    if (display_sel !== 2'b00 || fd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_iso: got sel=%b fv=%b want 00 0", display_sel, fd_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    pb_press  = 2'b00;
    enc_count = '0;
    lux_val   = '0;
    lux_ready = 1'b0;
    fd        = '0;
    fd_ready  = 1'b0;
    test_reset();
    test_select();
    test_ss_long();
    test_disp_nav();
    test_timeout();
    test_timeout_race();
`ifdef AUTO_REMETER_EN
    test_auto_remeter();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exp_ctrl_fsm.md
# exp_ctrl_fsm

- Parametrised successor of the light-meter control state machine.
- Sequences ISO / shutter-speed / aperture selection from the push button and encoder.
- Runs a lux-meter read and a flash-LUT read, each over a valid/ready handshake, then displays the LUT result.
- New behaviour: configurable widths, a per-handshake timeout with an error state and an `err` flag, lux capture on handshake, and optional periodic automatic re-metering.

## Interface
Parameters:
- `SET_W`, default 4: width of each setting value (ISO, SS, F) and of `enc_count`.
- `LUX_W`, default 8: lux value width.
- `ADDR_W`, default 24: flash address width. Must satisfy `ADDR_W >= 3*SET_W + LUX_W`.
- `TIMEOUT`, default 255: maximum cycles a request may wait for ready. Must be ≥ 1.
- `REMETER_PERIOD`, default 1000000: cycles between automatic re-meters (only used with `AUTO_REMETER_EN`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pb_press` in 2: button event, sampled every cycle. 00 none, 01 short, 10 long, 11 extra-long.
- `enc_count` in SET_W: encoder value.
- `lux_val` in LUX_W: lux-meter result.
- `lux_ready` in 1: lux-meter response strobe.
- `lux_valid` out 1: lux read request.
- `fd` in 8: flash data.
- `fd_ready` in 1: flash response strobe.
- `fd_address` out ADDR_W: LUT address.
- `fd_valid` out 1: flash read request.
- `display_out` out 4: digit value.
- `display_sel` out 2: display mode. 00 ISO, 01 SS, 10 F, 11 exposure/status.
- `err` out 1: sticky error flag, cleared on leaving ERR.

## Operation
- States: IDLE, ISO_SEL, SS_SEL, F_SEL, METER, LUT, DISP, ERR. Any unencoded state goes to IDLE.
- IDLE: clears settings, `lux_q`, `prev_sel`=SS_SEL and `f_set`, then goes to ISO_SEL. Outputs as at reset.
- ISO_SEL: latches `iso`=`enc_count`; `display_sel`=00; `display_out`=`enc_count[3:0]` (zero-extended if SET_W<4). Short press → SS_SEL.
- SS_SEL: latches `ss`; `display_sel`=01; `prev_sel`=SS_SEL.
  - short → F_SEL.
  - long with `f_set`=1 → METER.
  - extra-long → ISO_SEL.
- F_SEL: latches `f`; sets `f_set`; `display_sel`=10; `prev_sel`=F_SEL.
  - short → SS_SEL.
  - long → METER.
  - extra-long → ISO_SEL.
- METER: `lux_valid`=1 while waiting; `display_sel`=11, `display_out`=4'h2. On `lux_ready`=1: capture `lux_q`=`lux_val`, drop `lux_valid` on the same edge, go to LUT.
- LUT: `fd_address`={zeros, iso, ss, f, lux_q}, registered on LUT entry. `fd_valid`=1 while waiting. On `fd_ready`=1: capture `res_q`=`fd[2:0]`, drop `fd_valid`, go to DISP.
- DISP: `display_out`={1'b0,`res_q`}; `display_sel`=11.
  - short → METER.
  - long → `prev_sel`.
  - extra-long → ISO_SEL.
- Timeout: a counter clears on METER/LUT entry and increments each waiting cycle. If ready has not arrived when the counter equals `TIMEOUT`, go to ERR with valid deasserted. Ready and timeout in the same cycle: ready wins.
- ERR: `err`=1; `display_sel`=11; `display_out`=4'hE; both valids 0. Any nonzero `pb_press` → ISO_SEL with `err`=0. Settings are retained.
- `pb_press` is ignored in METER and LUT.

## Timing
- Reset values: `lux_valid`=0, `fd_valid`=0, `fd_address`=0, `display_out`=4'b1000, `display_sel`=00, `err`=0. State is IDLE.
- After `rst` falls: one IDLE cycle, then ISO_SEL.
- Outputs are registered and reflect the state entered on the previous edge.
- Handshakes:
  - Valid rises on the first clock edge inside METER/LUT.
  - Ready is sampled on each edge while valid=1.
  - With ready high at the first sample, minimum METER→LUT→DISP is 2 cycles per stage.
  - Ready while valid=0 is ignored.
- Reset asserted mid-handshake: valid drops on that edge; no capture.

## Configuration
- `AUTO_REMETER_EN` defined:
  - In DISP a counter counts cycles; at `REMETER_PERIOD`, go to METER.
  - The counter clears on DISP entry and on any press.
  - A button transition on the same cycle takes priority.
- Undefined: DISP holds until a press; no counter is instantiated.

## Test plan
- Reset then select: enc 3 in ISO, short; enc 5 in SS, short; enc 7 in F, long.
  - Expect: display_sel 00→01→10→11; METER entered.
  - lux_ready=1 with lux_val 8'h40 → fd_address 24'h035740.
  - fd_ready with fd 8'h06 → display_out 4'h6.
- Long press in SS with `f_set`=0 → stays SS_SEL. Repeat after visiting F_SEL → goes to METER.
- lux_ready never asserted, TIMEOUT=4:
  - ERR after 4 waiting cycles; err=1; lux_valid=0; display_out 4'hE.
  - Short press → ISO_SEL; err=0; iso unchanged.
- DISP with long press after entry via F_SEL → F_SEL. Extra-long press → ISO_SEL.
- fd_ready and timeout on the same cycle → DISP, err=0.
- `AUTO_REMETER_EN`, REMETER_PERIOD=10: idle in DISP → METER at cycle 10. A short press at cycle 9 → METER via button, counter cleared.
